// File: rtl/csr_pkg.sv
// Shared constants for the CSR access path: CSR numbers, op encodings,
// FSM states and write-select bit positions.
package csr_pkg;

    // CSR numbers handled by this unit
    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;

    // Bit positions inside the one-hot write select (14 and 15 reserved)
    localparam int unsigned SEL_CRMD   = 0;
    localparam int unsigned SEL_PRMD   = 1;
    localparam int unsigned SEL_ECFG   = 2;
    localparam int unsigned SEL_ESTAT  = 3;
    localparam int unsigned SEL_ERA    = 4;
    localparam int unsigned SEL_BADV   = 5;
    localparam int unsigned SEL_EENTRY = 6;
    localparam int unsigned SEL_SAVE0  = 7;
    localparam int unsigned SEL_SAVE1  = 8;
    localparam int unsigned SEL_SAVE2  = 9;
    localparam int unsigned SEL_SAVE3  = 10;
    localparam int unsigned SEL_TID    = 11;
    localparam int unsigned SEL_TCFG   = 12;
    localparam int unsigned SEL_TICLR  = 13;

    // CSR instruction kinds; the spare encoding behaves as a read
    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_XCHG = 2'b10,
        OP_RSV  = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

endpackage

// File: rtl/csr_access_unit_if.sv
// Commit-side request/response handshake of the CSR access unit.
interface csr_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [13:0] req_csr_num;
    logic [31:0] req_wdata;
    logic [31:0] req_mask;
    logic [5:0]  req_tag;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [5:0]  rsp_tag;
    logic        rsp_illegal;

    // Commit stage side
    modport master (
        output req_valid, req_op, req_csr_num, req_wdata, req_mask, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_tag, rsp_illegal,
        output rsp_ready
    );

    // CSR access unit side
    modport slave (
        input  req_valid, req_op, req_csr_num, req_wdata, req_mask, req_tag,
        output req_ready,
        output rsp_valid, rsp_data, rsp_tag, rsp_illegal,
        input  rsp_ready
    );

endinterface

// File: rtl/csr_num_decode.sv
// CSR number decoder: one-hot write select plus a legal flag for the
// implemented register set. Purely combinational.
module csr_num_decode
    import csr_pkg::*;
(
    input  logic [13:0] i_num,
    output logic [15:0] o_sel,
    output logic        o_legal
);

    // Map each implemented CSR number onto its write-select bit
    always_comb begin
        o_sel = '0;
        case (i_num)
            CSR_CRMD:   o_sel[SEL_CRMD]   = 1'b1;
            CSR_PRMD:   o_sel[SEL_PRMD]   = 1'b1;
            CSR_ECFG:   o_sel[SEL_ECFG]   = 1'b1;
            CSR_ESTAT:  o_sel[SEL_ESTAT]  = 1'b1;
            CSR_ERA:    o_sel[SEL_ERA]    = 1'b1;
            CSR_BADV:   o_sel[SEL_BADV]   = 1'b1;
            CSR_EENTRY: o_sel[SEL_EENTRY] = 1'b1;
            CSR_SAVE0:  o_sel[SEL_SAVE0]  = 1'b1;
            CSR_SAVE1:  o_sel[SEL_SAVE1]  = 1'b1;
            CSR_SAVE2:  o_sel[SEL_SAVE2]  = 1'b1;
            CSR_SAVE3:  o_sel[SEL_SAVE3]  = 1'b1;
            CSR_TID:    o_sel[SEL_TID]    = 1'b1;
            CSR_TCFG:   o_sel[SEL_TCFG]   = 1'b1;
            CSR_TICLR:  o_sel[SEL_TICLR]  = 1'b1;
            default:    o_sel = '0;
        endcase
    end

    assign o_legal = |o_sel;

endmodule

// File: rtl/csr_access_unit.sv
// Executes committed csrrd/csrwr/csrxchg: reads the old CSR value, forms
// the new value, issues a one-cycle one-hot write and returns the old
// value with its ROB tag through a valid/ready response.
module csr_access_unit
    import csr_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    csr_access_unit_if.slave   bus,
    input  logic               flush,
    output logic [13:0]        csr_rd_num,
    input  logic [31:0]        csr_rd_data,
    output logic [15:0]        csr_wr_sel,
    output logic [31:0]        csr_wr_data
);

    csr_state_e  r_state;
    csr_op_e     r_op;
    logic [13:0] r_num;
    logic [31:0] r_wdata;
    logic [31:0] r_mask;
    logic [5:0]  r_tag;
    logic [31:0] r_old;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [5:0]  r_rsp_tag;
    logic        r_rsp_illegal;

    logic [15:0] w_sel;
    logic        w_legal;
    logic        w_is_write_op;
    logic        w_wr_active;
    logic [31:0] w_new_data;

    csr_num_decode u_decode (
        .i_num   (r_num),
        .o_sel   (w_sel),
        .o_legal (w_legal)
    );

    assign w_is_write_op = (r_op == OP_WR) || (r_op == OP_XCHG);

    // New value: full write, or masked merge of write data into old value
    always_comb begin
        w_new_data = r_wdata;
        if (r_op == OP_XCHG) begin
            w_new_data = (r_wdata & r_mask) | (r_old & ~r_mask);
        end
    end

    // Write strobe is decoded from the held state so flush can kill it in
    // the very cycle it would otherwise be issued.
    assign w_wr_active = (r_state == ST_WRITE) && !flush;
    assign csr_wr_sel  = w_wr_active ? w_sel      : '0;
    assign csr_wr_data = w_wr_active ? w_new_data : '0;
    assign csr_rd_num  = r_num;

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_tag     = r_rsp_tag;
    assign bus.rsp_illegal = r_rsp_illegal;

    // Control FSM with operand capture and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_RD;
            r_num         <= '0;
            r_wdata       <= '0;
            r_mask        <= '0;
            r_tag         <= '0;
            r_old         <= '0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_tag     <= '0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && !flush) begin
                        r_op        <= csr_op_e'(bus.req_op);
                        r_num       <= bus.req_csr_num;
                        r_wdata     <= bus.req_wdata;
                        r_mask      <= bus.req_mask;
                        r_tag       <= bus.req_tag;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (flush) begin
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_old <= w_legal ? csr_rd_data : '0;
                        if (w_legal && w_is_write_op) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_data    <= w_legal ? csr_rd_data : '0;
                            r_rsp_tag     <= r_tag;
                            r_rsp_illegal <= !w_legal;
                            r_state       <= ST_RESP;
                        end
                    end
                end
                ST_WRITE: begin
                    if (flush) begin
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= r_old;
                        r_rsp_tag     <= r_tag;
                        r_rsp_illegal <= 1'b0;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (flush || bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Randomised bench for csr_access_unit with a small CSR file and an
// array-based reference model of the architectural CSR contents.
module tb_csr_access_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [13:0] csr_rd_num;
    logic [31:0] csr_rd_data;
    logic [15:0] csr_wr_sel;
    logic [31:0] csr_wr_data;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .flush       (flush),
        .csr_rd_num  (csr_rd_num),
        .csr_rd_data (csr_rd_data),
        .csr_wr_sel  (csr_wr_sel),
        .csr_wr_data (csr_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Implemented CSR numbers, listed in write-select bit order
    logic [13:0] legal_nums [14] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006,
                                     14'h007, 14'h00C, 14'h030, 14'h031, 14'h032,
                                     14'h033, 14'h040, 14'h041, 14'h044};

    logic [31:0] file_regs [16];
    logic [31:0] ref_regs  [16];
    int          rd_idx;

    function automatic int tb_idx(input logic [13:0] n);
        for (int i = 0; i < 14; i++) begin
            if (legal_nums[i] == n) return i;
        end
        return -1;
    endfunction

    // CSR file read port
    always_comb begin
        rd_idx      = tb_idx(csr_rd_num);
        csr_rd_data = (rd_idx >= 0) ? file_regs[rd_idx] : 32'hDEAD_BEEF;
    end

    // CSR file write port
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) file_regs[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (csr_wr_sel[i]) file_regs[i] <= csr_wr_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One CSR op. flush_at: 0 none, 1 during READ, 2 during WRITE, 3 during RESP.
    task automatic run_op(input logic [1:0] op, input logic [13:0] num,
                          input logic [31:0] wd, input logic [31:0] mk,
                          input logic [5:0] tg, input int flush_at_in, input int hold);
        int          idx;
        int          flush_at;
        logic        legal;
        logic        is_wr;
        logic [31:0] old_v;
        logic [31:0] new_v;
        logic [15:0] exp_sel;
        idx      = tb_idx(num);
        legal    = (idx >= 0);
        old_v    = legal ? ref_regs[idx] : 32'h0;
        is_wr    = legal && (op == 2'b01 || op == 2'b10);
        new_v    = (op == 2'b01) ? wd : ((wd & mk) | (old_v & ~mk));
        exp_sel  = is_wr ? (16'h0001 << idx) : 16'h0000;
        flush_at = flush_at_in;
        if (flush_at == 2 && !is_wr) flush_at = 0;

        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_csr_num = num;
        bus.req_wdata   = wd;
        bus.req_mask    = mk;
        bus.req_tag     = tg;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        // READ cycle
        @(negedge clk);
        chk("read_rd_num", 32'(csr_rd_num), 32'(num));
        chk("read_sel", 32'(csr_wr_sel), 32'd0);
        chk("read_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("read_req_ready", 32'(bus.req_ready), 32'd0);
        if (flush_at == 1) begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            @(negedge clk);
            chk("flush_rd_ready", 32'(bus.req_ready), 32'd1);
            chk("flush_rd_rsp", 32'(bus.rsp_valid), 32'd0);
            return;
        end

        if (is_wr) begin
            @(negedge clk);
            if (flush_at == 2) begin
                flush = 1'b1;
                #1;
                chk("flush_wr_sel", 32'(csr_wr_sel), 32'd0);
                @(posedge clk);
                #1 flush = 1'b0;
                @(negedge clk);
                chk("flush_wr_ready", 32'(bus.req_ready), 32'd1);
                chk("flush_wr_rsp", 32'(bus.rsp_valid), 32'd0);
                chk("flush_wr_sel2", 32'(csr_wr_sel), 32'd0);
                return;
            end
            chk("write_sel", 32'(csr_wr_sel), 32'(exp_sel));
            chk("write_data", csr_wr_data, new_v);
            chk("write_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            ref_regs[idx] = new_v;
        end

        // RESP
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_data", bus.rsp_data, old_v);
        chk("rsp_tag", 32'(bus.rsp_tag), 32'(tg));
        chk("rsp_illegal", 32'(bus.rsp_illegal), 32'(!legal));
        chk("rsp_sel", 32'(csr_wr_sel), 32'd0);
        if (flush_at == 3) begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            @(negedge clk);
            chk("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("flush_rsp_ready", 32'(bus.req_ready), 32'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_data", bus.rsp_data, old_v);
            chk("hold_tag", 32'(bus.rsp_tag), 32'(tg));
            chk("hold_illegal", 32'(bus.rsp_illegal), 32'(!legal));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_sel", 32'(csr_wr_sel), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_hs_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [13:0] r_num;
        int          r_flush;
        int          sel_roll;

        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_csr_num = '0;
        bus.req_wdata   = '0;
        bus.req_mask    = '0;
        bus.req_tag     = '0;
        bus.rsp_ready   = 1'b0;
        for (int i = 0; i < 16; i++) ref_regs[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        chk("rst_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
        chk("rst_wr_sel", 32'(csr_wr_sel), 32'd0);
        chk("rst_wr_data", csr_wr_data, 32'd0);
        chk("rst_rd_num", 32'(csr_rd_num), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op(2'b01, 14'h000, 32'h0000_0008, 32'h0, 6'd1, 0, 0);          // preload CRMD
        run_op(2'b00, 14'h000, 32'h0,         32'h0, 6'd5, 0, 0);          // RD CRMD
        run_op(2'b01, 14'h006, 32'h1C00_0100, 32'h0, 6'd2, 0, 0);          // WR ERA
        run_op(2'b10, 14'h000, 32'h0000_0007, 32'h0000_0003, 6'd3, 0, 0);  // XCHG CRMD
        run_op(2'b00, 14'h000, 32'h0,         32'h0, 6'd4, 0, 0);          // expect 0xB
        run_op(2'b01, 14'h099, 32'h1234_5678, 32'h0, 6'd6, 0, 0);          // illegal WR
        run_op(2'b01, 14'h030, 32'hCAFE_F00D, 32'h0, 6'd7, 2, 0);          // flush in WRITE
        run_op(2'b00, 14'h030, 32'h0,         32'h0, 6'd8, 0, 5);          // SAVE0 untouched, held rsp
        run_op(2'b11, 14'h006, 32'h0,         32'h0, 6'd9, 0, 0);          // spare op reads

        // Flush while idle blocks acceptance
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        flush         = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        @(negedge clk);
        chk("idle_flush_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_flush_rd_num", 32'(csr_rd_num), 32'h006);

        // Random ops
        for (int n = 0; n < 200; n++) begin
            r_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 8) r_num = legal_nums[$urandom_range(0, 13)];
            else                          r_num = 14'($urandom);
            sel_roll = $urandom_range(0, 19);
            r_flush  = (sel_roll < 3) ? sel_roll + 1 : 0;
            run_op(r_op, r_num, $urandom, $urandom, 6'($urandom), r_flush, $urandom_range(0, 3));
        end

        // Sweep all implemented CSRs so every write path is read back
        for (int i = 0; i < 14; i++) begin
            run_op(2'b00, legal_nums[i], 32'h0, 32'h0, 6'(i), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Executes committed CSR instructions (csrrd, csrwr, csrxchg) against the core's CSR file. It sits between the commit stage and the individual CSR registers (CRMD, PRMD, ESTAT, ...). It reads the old value, forms the new value (full write or masked exchange) and drives a one-cycle, one-hot write strobe with data to the target register. It returns the old value and ROB tag to commit through a valid/ready handshake.

## Interface
- No parameters; widths are fixed by the ISA.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  commit presents a CSR op.
- req_ready  out  1  unit accepts a request; high only in IDLE.
- req_op  in  2  00 RD, 01 WR, 10 XCHG; 11 is treated as RD.
- req_csr_num  in  14  CSR number.
- req_wdata  in  32  rd register value (write data).
- req_mask  in  32  rj register value (XCHG mask).
- req_tag  in  6  ROB id.
- csr_rd_num  out  14  CSR number being read.
- csr_rd_data  in  32  combinational read data from CSR file.
- csr_wr_sel  out  16  one-hot write enable: bit0 CRMD, 1 PRMD, 2 ECFG, 3 ESTAT, 4 ERA, 5 BADV, 6 EENTRY, 7–10 SAVE0–3, 11 TID, 12 TCFG, 13 TICLR, 14–15 reserved (always 0).
- csr_wr_data  out  32  new value, valid while any csr_wr_sel bit is set.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  commit consumes the response.
- rsp_data  out  32  old CSR value; 0 if illegal.
- rsp_tag  out  6  tag of the request.
- rsp_illegal  out  1  CSR number is unimplemented.
- flush  in  1  exception or ERTN at commit; cancels any op not yet written.

## Operation
- FSM states and transitions:
  - IDLE: on req_valid, capture op, num, wdata, mask and tag, then go to READ.
  - READ: drive csr_rd_num and register csr_rd_data as old. Go to WRITE for WR or XCHG on a legal number, otherwise go to RESP.
  - WRITE: csr_wr_sel = decoded one-hot, csr_wr_data = new, for exactly one cycle. Then go to RESP.
  - RESP: rsp_valid=1. Hold all rsp_* outputs stable until rsp_ready, then go to IDLE.
- New value:
  - WR: new = wdata.
  - XCHG: new = (wdata & mask) | (old & ~mask).
- Illegal number (not in the decode list):
  - No write.
  - rsp_illegal=1, rsp_data=0.
- flush:
  - In READ or WRITE: return to IDLE. csr_wr_sel is gated to 0 in the same cycle and no response is produced.
  - In RESP: drop the response and return to IDLE.
  - In IDLE: a request presented in the same cycle is not accepted.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_illegal=0, csr_wr_sel=0, csr_wr_data=0, csr_rd_num=0.

## Timing
- Request accepted at edge T0. READ occupies cycle T0+1. WRITE occupies T0+2. rsp_valid rises at T0+3 (T0+2 for RD or illegal).
- The write strobe is one cycle, so the CSR register updates at the edge ending WRITE. rsp_data always holds the pre-write value.
- One op is in flight at a time. Back-to-back throughput is one op per 4 cycles with rsp_ready held high.
- csr_wr_sel and csr_wr_data are combinational from state and registered operands. This lets flush suppress the write in the same cycle.
- Reset mid-operation: all state returns to reset values immediately; no partial write is issued after reset deasserts.

## Structure
- Package csr_pkg holds:
  - CSR number constants (CRMD=0x0, PRMD=0x1, ECFG=0x4, ESTAT=0x5, ERA=0x6, BADV=0x7, EENTRY=0xC, SAVE0–3=0x30–0x33, TID=0x40, TCFG=0x41, TICLR=0x44).
  - Op encodings.
  - FSM state enum.
  - Write-select bit indices.
- Sub-module csr_num_decode: 14-bit num in; 16-bit one-hot sel and legal flag out. It is purely combinational and shared with the read mux.

## Test plan
- RD CRMD: csr_rd_data=0x00000008, tag 5 -> no csr_wr_sel bit set; rsp at T0+2 with data 0x8, tag 5, illegal 0.
- WR ERA: wdata 0x1C000100, old 0x0 -> csr_wr_sel=0x0010 with data 0x1C000100 for exactly one cycle at T0+2; rsp_data 0x0.
- XCHG CRMD: old 0x00000008, wdata 0x00000007, mask 0x00000003 -> csr_wr_data 0x0000000B, sel 0x0001; rsp_data 0x8.
- Illegal num 0x99, op WR -> no write; rsp_illegal 1, rsp_data 0.
- flush asserted during WRITE of SAVE0 -> csr_wr_sel stays 0, no rsp_valid; next cycle req_ready=1.
- rsp_ready held low for 5 cycles -> rsp_* stable, req_ready=0 throughout; a new request is accepted the cycle after the handshake.
